// File: rtl/rot_pkg.sv
// rot_pkg: shared definitions for the image rotate tile address generator.
//   - mode encodings for I_MODE
//   - FSM state enum
//   - ceil_tile(): rounds an image dimension up to a whole number of tiles
package rot_pkg;

    localparam logic [2:0] MODE_ROT0   = 3'd0;
    localparam logic [2:0] MODE_ROT90  = 3'd1;
    localparam logic [2:0] MODE_ROT180 = 3'd2;
    localparam logic [2:0] MODE_ROT270 = 3'd3;
    localparam logic [2:0] MODE_HFLIP  = 3'd4;
    localparam logic [2:0] MODE_VFLIP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        WRITE,
        DONE
    } state_t;

    // Result is one bit wider than dim so a caller can detect that the
    // padded size no longer fits its own dimension width.
    function automatic logic [32:0] ceil_tile(input logic [31:0] dim,
                                              input int unsigned tile);
        logic [32:0] mask;
        mask = ~33'(tile - 1);
        return ({1'b0, dim} + 33'(tile - 1)) & mask;
    endfunction

endpackage

// File: rtl/rot_tile_map.sv
// rot_tile_map: combinational source-tile to destination-tile placement.
//   mode   : rotate/flip mode (rot_pkg encodings; invalid codes map as rot0)
//   tx, ty : source tile column / row
//   wt, ht : image size in tiles
//   dc, dr : destination tile column / row
//   swap   : 1 when the destination pitch is the padded height (rot90/rot270)
module rot_tile_map
    import rot_pkg::*;
#(
    parameter int unsigned DIM_W = 16
) (
    input  logic [2:0]       mode,
    input  logic [DIM_W-1:0] tx,
    input  logic [DIM_W-1:0] ty,
    input  logic [DIM_W-1:0] wt,
    input  logic [DIM_W-1:0] ht,
    output logic [DIM_W-1:0] dc,
    output logic [DIM_W-1:0] dr,
    output logic             swap
);

    logic [DIM_W-1:0] tx_mir;
    logic [DIM_W-1:0] ty_mir;

    assign tx_mir = wt - DIM_W'(1) - tx;
    assign ty_mir = ht - DIM_W'(1) - ty;

    always_comb begin
        dc   = tx;
        dr   = ty;
        swap = 1'b0;
        case (mode)
            MODE_ROT90: begin
                dc   = ty_mir;
                dr   = tx;
                swap = 1'b1;
            end
            MODE_ROT180: begin
                dc = tx_mir;
                dr = ty_mir;
            end
            MODE_ROT270: begin
                dc   = ty;
                dr   = tx_mir;
                swap = 1'b1;
            end
            MODE_HFLIP: dc = tx_mir;
            MODE_VFLIP: dr = ty_mir;
            default: ;
        endcase
    end

endmodule

// File: rtl/rot_tile_agen.sv
// rot_tile_agen: tile-based row address generator for the image rotate engine.
// Walks the padded source image tile by tile (ty fastest), issuing TILE row
// reads then TILE row writes per tile, the write tile placed per I_MODE.
//   I_HCLK/I_HRESET      : clock, synchronous active-high reset
//   I_START, I_MODE      : start pulse (IDLE only) and rotate/flip mode
//   I_WIDTH/I_HEIGHT     : image size in pixels
//   I_SRC_BASE/I_DST_BASE: buffer base addresses
//   I_READY              : DMA accepts the current request
//   O_VALID/O_ADDR/O_WRITE/O_LEN/O_ROW : request to the DMA master
//   O_BUSY/O_DONE/O_ERR  : status; DONE and ERR are one-cycle pulses
// Build option ROT_ABORT_EN adds I_ABORT: stop after the pending request.
module rot_tile_agen
    import rot_pkg::*;
#(
    parameter int unsigned TILE   = 8,
    parameter int unsigned BPP    = 3,
    parameter int unsigned DIM_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     I_HCLK,
    input  logic                     I_HRESET,
    input  logic                     I_START,
    input  logic [2:0]               I_MODE,
    input  logic [DIM_W-1:0]         I_WIDTH,
    input  logic [DIM_W-1:0]         I_HEIGHT,
    input  logic [ADDR_W-1:0]        I_SRC_BASE,
    input  logic [ADDR_W-1:0]        I_DST_BASE,
    input  logic                     I_READY,
`ifdef ROT_ABORT_EN
    input  logic                     I_ABORT,
`endif
    output logic                     O_VALID,
    output logic [ADDR_W-1:0]        O_ADDR,
    output logic                     O_WRITE,
    output logic [7:0]               O_LEN,
    output logic [$clog2(TILE)-1:0]  O_ROW,
    output logic                     O_BUSY,
    output logic                     O_DONE,
    output logic                     O_ERR
);

    localparam int unsigned      LOG_T    = $clog2(TILE);
    localparam logic [LOG_T-1:0] LAST_ROW = LOG_T'(TILE - 1);

    state_t             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]   wp_q, wp_d, dstw_q, dstw_d;
    logic [DIM_W-1:0]   wt_q, wt_d, ht_q, ht_d;
    logic [DIM_W-1:0]   tx_q, tx_d, ty_q, ty_d;
    logic [ADDR_W-1:0]  src_pitch_q, src_pitch_d, dst_pitch_q, dst_pitch_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LOG_T-1:0]   row_q, row_d;
    logic               valid_q, valid_d, write_q, write_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic abort;
`ifdef ROT_ABORT_EN
    assign abort = I_ABORT;
`else
    assign abort = 1'b0;
`endif

    logic [DIM_W-1:0] dc, dr;
    logic             swap;

    rot_tile_map #(.DIM_W(DIM_W)) u_map (
        .mode (mode_q),
        .tx   (tx_q),
        .ty   (ty_q),
        .wt   (wt_q),
        .ht   (ht_q),
        .dc   (dc),
        .dr   (dr),
        .swap (swap)
    );

    // Start validation on the live inputs (padded size must fit DIM_W bits).
    logic [DIM_W:0] in_wp, in_hp;
    logic           start_bad;
    assign in_wp     = (DIM_W+1)'(ceil_tile(32'(I_WIDTH), TILE));
    assign in_hp     = (DIM_W+1)'(ceil_tile(32'(I_HEIGHT), TILE));
    assign start_bad = (I_MODE > MODE_VFLIP) || (I_WIDTH == '0) ||
                       (I_HEIGHT == '0) || in_wp[DIM_W] || in_hp[DIM_W];

    // Geometry from latched sizes; overflow was already rejected.
    logic [DIM_W-1:0] su_wp, su_hp;
    assign su_wp = DIM_W'(ceil_tile(32'(w_q), TILE));
    assign su_hp = DIM_W'(ceil_tile(32'(h_q), TILE));

    logic             last_ty, last_tile;
    logic [DIM_W-1:0] next_tx, next_ty;
    assign last_ty   = (ty_q == ht_q - DIM_W'(1));
    assign last_tile = last_ty && (tx_q == wt_q - DIM_W'(1));
    assign next_tx   = last_ty ? tx_q + DIM_W'(1) : tx_q;
    assign next_ty   = last_ty ? '0 : ty_q + DIM_W'(1);

    // Tile base addresses: (row*pitch_px + col)*TILE*BPP, rows within a tile
    // then advance by adding the byte pitch.
    logic [ADDR_W-1:0] rd_base, wr_base;
    assign rd_base = src_q + ADDR_W'(BPP) *
                     ((ADDR_W'(next_ty) * ADDR_W'(wp_q) + ADDR_W'(next_tx)) << LOG_T);
    assign wr_base = dst_q + ADDR_W'(BPP) *
                     ((ADDR_W'(dr) * ADDR_W'(dstw_q) + ADDR_W'(dc)) << LOG_T);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        src_d       = src_q;
        dst_d       = dst_q;
        w_d         = w_q;
        h_d         = h_q;
        wp_d        = wp_q;
        dstw_d      = dstw_q;
        wt_d        = wt_q;
        ht_d        = ht_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        src_pitch_d = src_pitch_q;
        dst_pitch_d = dst_pitch_q;
        addr_d      = addr_q;
        row_d       = row_q;
        valid_d     = valid_q;
        write_d     = write_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_START) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = I_MODE;
                        src_d   = I_SRC_BASE;
                        dst_d   = I_DST_BASE;
                        w_d     = I_WIDTH;
                        h_d     = I_HEIGHT;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                wp_d        = su_wp;
                wt_d        = su_wp >> LOG_T;
                ht_d        = su_hp >> LOG_T;
                dstw_d      = swap ? su_hp : su_wp;
                src_pitch_d = ADDR_W'(su_wp) * ADDR_W'(BPP);
                dst_pitch_d = ADDR_W'(swap ? su_hp : su_wp) * ADDR_W'(BPP);
                tx_d        = '0;
                ty_d        = '0;
                row_d       = '0;
                addr_d      = src_q;
                write_d     = 1'b0;
                if (abort) begin
                    state_d = DONE;
                end else begin
                    valid_d = 1'b1;
                    state_d = READ;
                end
            end
            READ, WRITE: begin
                if (valid_q && I_READY) begin
                    if (abort) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else if (row_q != LAST_ROW) begin
                        row_d  = row_q + LOG_T'(1);
                        addr_d = addr_q + ((state_q == WRITE) ? dst_pitch_q : src_pitch_q);
                    end else if (state_q == READ) begin
                        row_d   = '0;
                        write_d = 1'b1;
                        addr_d  = wr_base;
                        state_d = WRITE;
                    end else if (last_tile) begin
                        row_d   = '0;
                        valid_d = 1'b0;
                        write_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        row_d   = '0;
                        write_d = 1'b0;
                        tx_d    = next_tx;
                        ty_d    = next_ty;
                        addr_d  = rd_base;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            wp_q        <= '0;
            dstw_q      <= '0;
            wt_q        <= '0;
            ht_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            src_pitch_q <= '0;
            dst_pitch_q <= '0;
            addr_q      <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            w_q         <= w_d;
            h_q         <= h_d;
            wp_q        <= wp_d;
            dstw_q      <= dstw_d;
            wt_q        <= wt_d;
            ht_q        <= ht_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            src_pitch_q <= src_pitch_d;
            dst_pitch_q <= dst_pitch_d;
            addr_q      <= addr_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign O_VALID = valid_q;
    assign O_ADDR  = addr_q;
    assign O_WRITE = write_q;
    assign O_LEN   = 8'(TILE * BPP);
    assign O_ROW   = row_q;
    assign O_BUSY  = busy_q;
    assign O_DONE  = done_q;
    assign O_ERR   = err_q;

endmodule

// File: tb/tb_rot_tile_agen.sv
// tb_rot_tile_agen: scoreboard bench for rot_tile_agen (TILE=8, BPP=3).
// Expected requests are pushed from the address formulas when a job starts
// and popped as the DUT transfers them.
module tb_rot_tile_agen;

    localparam int unsigned T = 8;
    localparam int unsigned B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic [15:0] width, height;
    logic [31:0] src, dst;
    logic        ready;
    logic        O_VALID, O_WRITE, O_BUSY, O_DONE, O_ERR;
    logic [31:0] O_ADDR;
    logic [7:0]  O_LEN;
    logic [2:0]  O_ROW;

    rot_tile_agen #(.TILE(8), .BPP(3), .DIM_W(16), .ADDR_W(32)) dut (
        .I_HCLK     (clk),
        .I_HRESET   (rst),
        .I_START    (start),
        .I_MODE     (mode),
        .I_WIDTH    (width),
        .I_HEIGHT   (height),
        .I_SRC_BASE (src),
        .I_DST_BASE (dst),
        .I_READY    (ready),
`ifdef ROT_ABORT_EN
        .I_ABORT    (1'b0),
`endif
        .O_VALID    (O_VALID),
        .O_ADDR     (O_ADDR),
        .O_WRITE    (O_WRITE),
        .O_LEN      (O_LEN),
        .O_ROW      (O_ROW),
        .O_BUSY     (O_BUSY),
        .O_DONE     (O_DONE),
        .O_ERR      (O_ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  row;
    } req_t;

    req_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   first_v = -1;
    int   done_cyc = -1;
    int   req_cnt = 0;
    logic mon_en = 1'b0;
    logic hold_pend = 1'b0;
    logic [31:0] hold_addr;
    logic [2:0]  hold_row;
    logic        hold_wr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, a valid&ready here transfers at the next edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (hold_pend) begin
                check_eq("hold_valid", 64'(O_VALID), 64'(1));
                check_eq("hold_addr", 64'(O_ADDR), 64'(hold_addr));
                check_eq("hold_row", 64'(O_ROW), 64'(hold_row));
                check_eq("hold_wr", 64'(O_WRITE), 64'(hold_wr));
            end
            hold_pend = O_VALID && !ready;
            hold_addr = O_ADDR;
            hold_row  = O_ROW;
            hold_wr   = O_WRITE;
            if (O_VALID && first_v < 0) first_v = cyc;
            if (O_DONE && done_cyc < 0) done_cyc = cyc;
            if (O_VALID && ready) begin
                req_cnt++;
                check_eq("req_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    req_t e;
                    e = exp_q.pop_front();
                    check_eq("addr", 64'(O_ADDR), 64'(e.addr));
                    check_eq("write", 64'(O_WRITE), 64'(e.wr));
                    check_eq("row", 64'(O_ROW), 64'(e.row));
                end
            end
        end
    end

    task automatic push_job(input logic [2:0] m, input int unsigned w, input int unsigned h,
                            input logic [31:0] s, input logic [31:0] d);
        int unsigned wp, hp, wt, ht, dstw, dc, dr;
        req_t r;
        wp   = (w + T - 1) / T * T;
        hp   = (h + T - 1) / T * T;
        wt   = wp / T;
        ht   = hp / T;
        dstw = (m == 3'd1 || m == 3'd3) ? hp : wp;
        for (int unsigned tx = 0; tx < wt; tx++) begin
            for (int unsigned ty = 0; ty < ht; ty++) begin
                for (int unsigned k = 0; k < T; k++) begin
                    r.addr = s + ((ty * T + k) * wp + tx * T) * B;
                    r.wr   = 1'b0;
                    r.row  = 3'(k);
                    exp_q.push_back(r);
                end
                case (m)
                    3'd1: begin dc = ht - 1 - ty; dr = tx;          end
                    3'd2: begin dc = wt - 1 - tx; dr = ht - 1 - ty; end
                    3'd3: begin dc = ty;          dr = wt - 1 - tx; end
                    3'd4: begin dc = wt - 1 - tx; dr = ty;          end
                    3'd5: begin dc = tx;          dr = ht - 1 - ty; end
                    default: begin dc = tx;       dr = ty;          end
                endcase
                for (int unsigned k = 0; k < T; k++) begin
                    r.addr = d + ((dr * T + k) * dstw + dc * T) * B;
                    r.wr   = 1'b1;
                    r.row  = 3'(k);
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic run_job(input string name, input logic [2:0] m, input int unsigned w,
                           input int unsigned h, input logic [31:0] s, input logic [31:0] d,
                           input bit stall, input bit noise);
        int n_req, stalls, st_cyc;
        exp_q.delete();
        push_job(m, w, h, s, d);
        n_req    = exp_q.size();
        req_cnt  = 0;
        first_v  = -1;
        done_cyc = -1;
        stalls   = 0;
        @(posedge clk); #1;
        mode = m; width = 16'(w); height = 16'(h); src = s; dst = d; start = 1'b1;
        @(posedge clk); #1;
        st_cyc = cyc - 1;
        start  = 1'b0;
        for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
            @(posedge clk); #1;
            if (noise && i == 4) begin
                start = 1'b1; mode = 3'd7; width = 16'd0;
            end else begin
                start = 1'b0;
            end
            if (stall && stalls < 5 && O_VALID && !O_WRITE && O_ROW == 3'd3 && req_cnt < T) begin
                ready = 1'b0;
                stalls++;
            end else begin
                ready = 1'b1;
            end
        end
        ready = 1'b1;
        start = 1'b0;
        check_eq({name, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
        check_eq({name, "_latency"}, 64'(first_v - st_cyc), 64'(2));
        check_eq({name, "_done_time"}, 64'(done_cyc - first_v), 64'(n_req + stalls + 1));
        check_eq({name, "_count"}, 64'(req_cnt), 64'(n_req));
        check_eq({name, "_leftover"}, 64'(exp_q.size()), 64'(0));
        if (stall) check_eq({name, "_stalls"}, 64'(stalls), 64'(5));
        check_eq({name, "_done_1cyc"}, 64'(O_DONE), 64'(0));
        check_eq({name, "_idle"}, 64'(O_BUSY), 64'(0));
    endtask

    task automatic run_err(input string name, input logic [2:0] m, input int unsigned w,
                           input int unsigned h);
        exp_q.delete();
        @(posedge clk); #1;
        mode = m; width = 16'(w); height = 16'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({name, "_err"}, 64'(O_ERR), 64'(1));
        check_eq({name, "_busy"}, 64'(O_BUSY), 64'(0));
        check_eq({name, "_valid"}, 64'(O_VALID), 64'(0));
        @(negedge clk);
        check_eq({name, "_err_1cyc"}, 64'(O_ERR), 64'(0));
        check_eq({name, "_busy2"}, 64'(O_BUSY), 64'(0));
        repeat (4) @(negedge clk);
        check_eq({name, "_still_idle"}, 64'(O_BUSY | O_VALID), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        rst = 1'b1; start = 1'b0; mode = '0; width = '0; height = '0;
        src = '0; dst = '0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 64'(O_VALID), 64'(0));
        check_eq("rst_addr", 64'(O_ADDR), 64'(0));
        check_eq("rst_row", 64'(O_ROW), 64'(0));
        check_eq("rst_flags", 64'({O_WRITE, O_BUSY, O_DONE, O_ERR}), 64'(0));
        check_eq("rst_len", 64'(O_LEN), 64'(24));

        run_job("m0_8x8", 3'd0, 8, 8, 32'h1000, 32'h8000, 1'b0, 1'b0);
        run_job("m1_16x8", 3'd1, 16, 8, 32'h0, 32'h0, 1'b0, 1'b1);
        run_job("m2_10x5", 3'd2, 10, 5, 32'h0, 32'h0, 1'b0, 1'b0);
        run_job("m3_24x16", 3'd3, 24, 16, 32'h200, 32'h6000, 1'b0, 1'b0);
        run_job("m5_8x24", 3'd5, 8, 24, 32'h300, 32'h7000, 1'b0, 1'b0);
        run_job("stall", 3'd0, 16, 16, 32'h4000, 32'hA000, 1'b1, 1'b0);
        run_job("wrap", 3'd4, 9, 9, 32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b0, 1'b0);

        run_err("mode6", 3'd6, 8, 8);
        run_err("w0", 3'd0, 0, 8);
        run_err("h0", 3'd2, 8, 0);
        run_err("ovf", 3'd0, 16'hFFF9, 8);

        // Reset in the middle of the write phase, then a clean restart.
        exp_q.delete();
        push_job(3'd0, 16, 16, 32'h0, 32'h5000);
        @(posedge clk); #1;
        mode = 3'd0; width = 16'd16; height = 16'd16; src = 32'h0; dst = 32'h5000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk); #1;
            if (O_WRITE && O_VALID) reached = 1'b1;
        end
        check_eq("reached_write", 64'(reached), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_valid", 64'(O_VALID), 64'(0));
        check_eq("mid_rst_busy", 64'(O_BUSY), 64'(0));
        check_eq("mid_rst_write", 64'(O_WRITE), 64'(0));
        check_eq("mid_rst_addr", 64'(O_ADDR), 64'(0));
        check_eq("mid_rst_row", 64'(O_ROW), 64'(0));
        exp_q.delete();
        hold_pend = 1'b0;
        run_job("restart_m4", 3'd4, 16, 16, 32'h2000, 32'h9000, 1'b0, 1'b0);
        check_eq("restart_count", 64'(req_cnt), 64'(64));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
